rc_nrzi_unstuff: RTL and testbench

- Receive-path successor to the fixed NRZI decoder: NRZI decode and bit unstuffing in one block, with a strobe-qualified input for oversampled clocks.
- Sits between rc_dpdm and the packet deserializer.
- Start/end framing pulses keep the existing handshake style. Adds stuff-error detection, a per-frame decoded-bit count and parametrised stuffing rules.

---
 rtl/rc_pkg.sv | 20 ++
 rtl/gen_dff.sv | 30 +++
 rtl/rc_ones_counter.sv | 43 ++++
 rtl/rc_nrzi_unstuff.sv | 161 ++++++++++++++++
 tb/tb_rc_nrzi_unstuff.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/rc_pkg.sv
// Shared types and constants for the rc_* receive path.
//   rc_state_t        : frame-level state of the NRZI decode / unstuff block
//   STUFF_LEN_DEFAULT : default number of decoded 1s that forces a stuffed 0
//   ones_cnt_w()      : width needed to hold a run-length count of 0..stuff_len
package rc_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DRAIN  = 2'd2,
        DONE   = 2'd3
    } rc_state_t;

    localparam int STUFF_LEN_DEFAULT = 6;

    function automatic int ones_cnt_w(input int stuff_len);
        return $clog2(stuff_len + 1);
    endfunction

endpackage

// File: rtl/gen_dff.sv
// Generic enabled register with an asynchronous reset value and a synchronous
// set value.
//   clk, rst_n : clock, asynchronous active-low reset (loads RST_VAL)
//   en         : load d
//   sync_set   : load SET_VAL; has priority over en
//   d, q       : data in / registered data out
module gen_dff #(
    parameter int           W       = 1,
    parameter logic [W-1:0] RST_VAL = '0,
    parameter logic [W-1:0] SET_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         sync_set,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= RST_VAL;
        end else if (sync_set) begin
            q <= SET_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/rc_ones_counter.sv
// Run-length counter of consecutive decoded 1s for bit unstuffing.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : restart the count (frame start)
//   en         : a decoded bit is being consumed this cycle
//   d          : the decoded bit
//   stuff_due  : STUFF_LEN ones have been seen; the current bit must be a 0
module rc_ones_counter
    import rc_pkg::*;
#(
    parameter int STUFF_LEN = STUFF_LEN_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    input  logic d,
    output logic stuff_due
);

    localparam int W = ones_cnt_w(STUFF_LEN);

    logic [W-1:0] cnt;

    assign stuff_due = (cnt == W'(STUFF_LEN));

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            // The owed bit (stuffed 0 or violation) always restarts the run.
            if (stuff_due || !d) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + W'(1);
            end
        end
    end

endmodule

// File: rtl/rc_nrzi_unstuff.sv
// NRZI decoder with bit unstuffing, between rc_dpdm and the packet deserializer.
//   clk, rst_n  : clock, asynchronous active-low reset
//   s_in        : raw NRZI line bit, qualified by bit_en
//   bit_en      : s_in carries a new bit this cycle
//   start_in    : one-cycle frame-start pulse
//   end_in      : one-cycle frame-end pulse
//   bit_out     : decoded, unstuffed data bit (valid with bit_valid)
//   bit_valid   : bit_out is valid this cycle
//   start_out   : one-cycle frame-start pulse to the deserializer
//   end_out     : one-cycle frame-end pulse
//   stuff_err   : one-cycle pulse on a stuffing violation
//   frame_err   : sticky error flag for the current frame
//   bit_count   : valid bits emitted this frame (saturating)
// All outputs are registered: one cycle after the sampling edge.
module rc_nrzi_unstuff
    import rc_pkg::*;
#(
    parameter int STUFF_LEN  = STUFF_LEN_DEFAULT,
    parameter bit STUFF_EN   = 1'b1,
    parameter bit IDLE_LEVEL = 1'b1,
    parameter int CNT_W      = 14
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_in,
    input  logic             bit_en,
    input  logic             start_in,
    input  logic             end_in,
    output logic             bit_out,
    output logic             bit_valid,
    output logic             start_out,
    output logic             end_out,
    output logic             stuff_err,
    output logic             frame_err,
    output logic [CNT_W-1:0] bit_count
);

    rc_state_t state, state_nxt;

    logic prev;
    logic d;
    logic stuff_due;
    logic start_acc;   // frame start accepted this cycle
    logic bit_act;     // a line bit is consumed by the run-length counter
    logic emit;        // decoded bit goes out this cycle
    logic violation;   // a 1 arrived where a stuffed 0 was owed

    // No transition on the line means a 1.
    assign d = ~(s_in ^ prev);

    gen_dff #(
        .W       (1),
        .RST_VAL (IDLE_LEVEL),
        .SET_VAL (IDLE_LEVEL)
    ) u_prev (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (bit_en && (state == ACTIVE || state == DRAIN)),
        .sync_set (start_acc),
        .d        (s_in),
        .q        (prev)
    );

    rc_ones_counter #(
        .STUFF_LEN (STUFF_LEN)
    ) u_ones (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (start_acc),
        .en        (bit_act),
        .d         (d),
        .stuff_due (stuff_due)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every signal driven here gets a default first so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        start_acc = 1'b0;
        bit_act   = 1'b0;
        emit      = 1'b0;
        violation = 1'b0;
        case (state)
            IDLE: begin
                // start wins over a simultaneous end_in
                if (start_in) begin
                    start_acc = 1'b1;
                    state_nxt = ACTIVE;
                end
            end
            ACTIVE: begin
                bit_act = bit_en;
                if (bit_en) begin
                    if (STUFF_EN && stuff_due) begin
                        // d=0 is the stuffed bit and is silently dropped
                        violation = d;
                    end else begin
                        emit = 1'b1;
                    end
                end
                if (violation) begin
                    state_nxt = DRAIN;
                end
                // The bit of this cycle is already handled; end takes effect after it.
                if (end_in) begin
                    state_nxt = DONE;
                end
            end
            DRAIN: begin
                if (end_in) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_out   <= 1'b0;
            bit_valid <= 1'b0;
            start_out <= 1'b0;
            end_out   <= 1'b0;
            stuff_err <= 1'b0;
            frame_err <= 1'b0;
            bit_count <= '0;
        end else begin
            bit_out   <= emit & d;
            bit_valid <= emit;
            start_out <= start_acc;
            // DONE is only ever entered from ACTIVE or DRAIN, so this is a pulse.
            end_out   <= (state_nxt == DONE);
            stuff_err <= violation;
            if (start_acc) begin
                frame_err <= 1'b0;
                bit_count <= '0;
            end else begin
                if (violation) begin
                    frame_err <= 1'b1;
                end
                if (emit && (bit_count != '1)) begin
                    bit_count <= bit_count + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_rc_nrzi_unstuff.sv
// Self-checking bench for rc_nrzi_unstuff. Two instances share the stimulus:
// dut (default stuffing rules) and dut_ns (STUFF_EN=0). Expected values come
// from a frame-level model that decodes the whole line stream and then walks
// the decoded bits applying the stuffing rules.
module tb_rc_nrzi_unstuff;

    localparam int STUFF_LEN = 6;
    localparam int CNT_W     = 14;

    logic clk = 1'b0;
    logic rst_n;
    logic s_in, bit_en, start_in, end_in;

    logic             bit_out, bit_valid, start_out, end_out, stuff_err, frame_err;
    logic [CNT_W-1:0] bit_count;
    logic             bit_out_ns, bit_valid_ns, start_out_ns, end_out_ns, stuff_err_ns, frame_err_ns;
    logic [CNT_W-1:0] bit_count_ns;

    int checks   = 0;
    int failures = 0;

    bit line_q[$];   // raw line bits of the frame under test
    bit dec_in[$];   // decoded bits used to build line_q
    bit dec[$];      // model: decoded line bits
    bit v1[$];       // model: bit emitted (stuffing enabled)
    bit e1[$];       // model: stuff_err pulse (stuffing enabled)
    int cnt1;
    bit ferr1;

    always #5 clk = ~clk;

    rc_nrzi_unstuff #(
        .STUFF_LEN (STUFF_LEN), .STUFF_EN (1'b1), .IDLE_LEVEL (1'b1), .CNT_W (CNT_W)
    ) dut (
        .clk (clk), .rst_n (rst_n), .s_in (s_in), .bit_en (bit_en),
        .start_in (start_in), .end_in (end_in),
        .bit_out (bit_out), .bit_valid (bit_valid), .start_out (start_out),
        .end_out (end_out), .stuff_err (stuff_err), .frame_err (frame_err),
        .bit_count (bit_count)
    );

    rc_nrzi_unstuff #(
        .STUFF_LEN (STUFF_LEN), .STUFF_EN (1'b0), .IDLE_LEVEL (1'b1), .CNT_W (CNT_W)
    ) dut_ns (
        .clk (clk), .rst_n (rst_n), .s_in (s_in), .bit_en (bit_en),
        .start_in (start_in), .end_in (end_in),
        .bit_out (bit_out_ns), .bit_valid (bit_valid_ns), .start_out (start_out_ns),
        .end_out (end_out_ns), .stuff_err (stuff_err_ns), .frame_err (frame_err_ns),
        .bit_count (bit_count_ns)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called on a falling edge: apply inputs, let one rising edge sample them,
    // return on the next falling edge with the registered outputs settled.
    task automatic step(input bit s, input bit en, input bit st, input bit ed);
        s_in = s; bit_en = en; start_in = st; end_in = ed;
        @(posedge clk);
        @(negedge clk);
        s_in = 1'b0; bit_en = 1'b0; start_in = 1'b0; end_in = 1'b0;
    endtask

    // NRZI: a 1 keeps the line level, a 0 toggles it; the line idles at J=1.
    task automatic encode();
        bit p = 1'b1;
        line_q.delete();
        foreach (dec_in[i]) begin
            bit s = dec_in[i] ? p : ~p;
            line_q.push_back(s);
            p = s;
        end
    endtask

    task automatic build_model();
        bit p = 1'b1;
        int run = 0;
        bit dead = 1'b0;
        dec.delete(); v1.delete(); e1.delete();
        cnt1 = 0; ferr1 = 1'b0;
        foreach (line_q[i]) begin
            dec.push_back(line_q[i] == p);
            p = line_q[i];
        end
        foreach (dec[i]) begin
            if (dead) begin
                v1.push_back(1'b0); e1.push_back(1'b0);
            end else if (run == STUFF_LEN) begin
                v1.push_back(1'b0); e1.push_back(dec[i]);
                if (dec[i]) begin
                    dead = 1'b1; ferr1 = 1'b1;
                end
                run = 0;
            end else begin
                v1.push_back(1'b1); e1.push_back(1'b0);
                cnt1++;
                run = dec[i] ? run + 1 : 0;
            end
        end
    endtask

    task automatic check_all_zero(input string name);
        check({name, ":rst_valid"}, 32'(bit_valid), 0);
        check({name, ":rst_bit"},   32'(bit_out),   0);
        check({name, ":rst_start"}, 32'(start_out), 0);
        check({name, ":rst_end"},   32'(end_out),   0);
        check({name, ":rst_serr"},  32'(stuff_err), 0);
        check({name, ":rst_ferr"},  32'(frame_err), 0);
        check({name, ":rst_cnt"},   32'(bit_count), 0);
    endtask

    task automatic run_frame(input string name, input int gap, input bit end_with_bit,
                             input int mid_start);
        int n;
        build_model();
        n = line_q.size();
        step(1'b0, 1'b0, 1'b1, 1'b0);
        check({name, ":start_out"},    32'(start_out),    1);
        check({name, ":start_out_ns"}, 32'(start_out_ns), 1);
        check({name, ":start_cnt"},    32'(bit_count),    0);
        check({name, ":start_ferr"},   32'(frame_err),    0);
        for (int i = 0; i < n; i++) begin
            for (int g = 1; g < gap; g++) begin
                step(1'b0, 1'b0, 1'b0, 1'b0);
                check({name, ":gap_valid"}, 32'(bit_valid | bit_valid_ns), 0);
            end
            step(line_q[i], 1'b1, (i == mid_start), end_with_bit && (i == n - 1));
            check($sformatf("%s:valid[%0d]", name, i), 32'(bit_valid), 32'(v1[i]));
            if (v1[i]) begin
                check($sformatf("%s:bit[%0d]", name, i), 32'(bit_out), 32'(dec[i]));
            end
            check($sformatf("%s:serr[%0d]", name, i), 32'(stuff_err), 32'(e1[i]));
            check($sformatf("%s:ns_valid[%0d]", name, i), 32'(bit_valid_ns), 1);
            check($sformatf("%s:ns_bit[%0d]", name, i), 32'(bit_out_ns), 32'(dec[i]));
            check($sformatf("%s:ns_serr[%0d]", name, i), 32'(stuff_err_ns), 0);
            check($sformatf("%s:start_quiet[%0d]", name, i), 32'(start_out), 0);
        end
        if (!end_with_bit) begin
            step(1'b0, 1'b0, 1'b0, 1'b1);
            check({name, ":end_valid"}, 32'(bit_valid), 0);
        end
        check({name, ":end_out"},    32'(end_out),      1);
        check({name, ":end_out_ns"}, 32'(end_out_ns),   1);
        check({name, ":end_start"},  32'(start_out),    0);
        check({name, ":cnt"},        32'(bit_count),    32'(cnt1));
        check({name, ":ferr"},       32'(frame_err),    32'(ferr1));
        check({name, ":ns_cnt"},     32'(bit_count_ns), 32'(n));
        check({name, ":ns_ferr"},    32'(frame_err_ns), 0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check({name, ":post_end"},   32'(end_out),      0);
        check({name, ":hold_cnt"},   32'(bit_count),    32'(cnt1));
        check({name, ":hold_ferr"},  32'(frame_err),    32'(ferr1));
    endtask

    initial begin
        rst_n = 1'b0;
        s_in = 1'b0; bit_en = 1'b0; start_in = 1'b0; end_in = 1'b0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Basic decode: line 1,0,0,1,1,1,0 -> 1,0,1,0,1,1,0, count 7
        line_q = '{1, 0, 0, 1, 1, 1, 0};
        run_frame("basic", 1, 1'b0, -1);
        check("basic:cnt7", 32'(bit_count), 7);

        // Unstuffing: six 1s, stuffed 0, then a 1
        dec_in = '{1, 1, 1, 1, 1, 1, 0, 1};
        encode();
        run_frame("unstuff", 1, 1'b0, -1);
        check("unstuff:cnt7", 32'(bit_count), 7);

        // Violation: seven 1s, then more bits
        dec_in = '{1, 1, 1, 1, 1, 1, 1, 0, 1, 0};
        encode();
        run_frame("viol", 1, 1'b0, -1);
        check("viol:cnt6", 32'(bit_count), 6);

        // Oversampled strobe, one bit every 4 cycles
        line_q = '{1, 0, 0, 1, 1, 1, 0};
        run_frame("strobe", 4, 1'b0, -1);

        // end_in together with the last bit_en
        run_frame("end_with_bit", 1, 1'b1, -1);

        // start_in mid-frame is ignored
        dec_in = '{0, 1, 1, 0, 1, 0, 0, 1, 1};
        encode();
        run_frame("mid_start", 2, 1'b0, 3);

        // start_in and end_in together in IDLE: start wins
        start_in = 1'b1; end_in = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_in = 1'b0; end_in = 1'b0;
        check("start_end:start_out", 32'(start_out), 1);
        check("start_end:end_out",   32'(end_out),   0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("start_end:close", 32'(end_out), 1);
        step(1'b0, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset after three bits of a frame
        line_q = '{1, 0, 0, 1, 1, 1, 0};
        step(1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(line_q[i], 1'b1, 1'b0, 1'b0);
        end
        check("rst_mid:pre_valid", 32'(bit_valid), 1);
        #2 rst_n = 1'b0;
        #1 check_all_zero("rst_mid");
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("rst_mid:no_end", 32'(end_out), 0);
        run_frame("after_rst", 1, 1'b0, -1);

        // Randomized frames biased toward long runs of 1s
        for (int f = 0; f < 8; f++) begin
            int len = $urandom_range(8, 40);
            dec_in.delete();
            for (int k = 0; k < len; k++) begin
                dec_in.push_back($urandom_range(0, 3) != 0);
            end
            encode();
            run_frame($sformatf("rand%0d", f), $urandom_range(1, 4),
                      1'($urandom_range(0, 1)), -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
